// File: rtl/sysid_check.sv
// Reads the sysid slave's ID and timestamp words over Avalon-MM and compares them
// against the expected build values. Runs once out of reset and again on each start in DONE.
module sysid_check #(
  parameter logic [31:0] ID_EXPECTED = 32'd651202559,
  parameter logic [31:0] TS_EXPECTED = 32'd1277427864,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [1:0] {RD_ID, RD_TS, COMPARE, DONE} state_t;

  typedef struct packed {
    logic        rd;
    logic        addr;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [31:0] id;
    logic [31:0] ts;
    logic [15:0] cnt;
  } regs_t;

  state_t state, state_nx;
  regs_t  r, r_nx;
  logic   accept;

  assign accept = r.rd & ~avm_waitrequest;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RD_ID;
      r     <= '0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
    end
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    case (state)
      RD_ID, RD_TS: begin
        // RD_ID with the strobe low only happens right after reset: launch the power-up check
        if (!r.rd) begin
          r_nx.rd   = 1'b1;
          r_nx.addr = 1'b0;
          r_nx.busy = 1'b1;
        end else if (accept) begin
          r_nx.cnt = '0;
          if (state == RD_ID) begin
            r_nx.id   = avm_readdata;
            r_nx.addr = 1'b1;
            state_nx  = RD_TS;
          end else begin
            r_nx.ts  = avm_readdata;
            r_nx.rd  = 1'b0;
            state_nx = COMPARE;
          end
        end else if (r.cnt == TMO) begin
          r_nx.rd   = 1'b0;
          r_nx.busy = 1'b0;
          r_nx.done = 1'b1;
          r_nx.fail = 1'b1;
          r_nx.tmo  = 1'b1;
          state_nx  = DONE;
        end else if (r.cnt != '1) begin
          r_nx.cnt = r.cnt + 16'd1;
        end
      end
      COMPARE: begin
        r_nx.busy = 1'b0;
        r_nx.done = 1'b1;
        r_nx.pass = (r.id == ID_EXPECTED) && (r.ts == TS_EXPECTED);
        r_nx.fail = !((r.id == ID_EXPECTED) && (r.ts == TS_EXPECTED));
        state_nx  = DONE;
      end
      DONE: begin
        // captured words are kept until the next read overwrites them
        if (start) begin
          r_nx.rd   = 1'b1;
          r_nx.addr = 1'b0;
          r_nx.busy = 1'b1;
          r_nx.done = 1'b0;
          r_nx.pass = 1'b0;
          r_nx.fail = 1'b0;
          r_nx.tmo  = 1'b0;
          r_nx.cnt  = '0;
          state_nx  = RD_ID;
        end
      end
      default: state_nx = RD_ID;
    endcase
  end

  assign avm_read    = r.rd;
  assign avm_address = r.addr;
  assign busy        = r.busy;
  assign done        = r.done;
  assign pass        = r.pass;
  assign fail        = r.fail;
  assign timeout     = r.tmo;
  assign id_word     = r.id;
  assign ts_word     = r.ts;

endmodule

// File: tb/tb_sysid_check.sv
// Bench for sysid_check: dut 0 uses default parameters, dut 1 uses TIMEOUT=4.
// A stall-count slave drives each read; an arithmetic model predicts latency and verdict.
module tb_sysid_check;

  localparam logic [31:0] IDX = 32'd651202559;
  localparam logic [31:0] TSX = 32'd1277427864;

  logic        clk;
  logic [1:0]  rstn, st, wr, rd, addr, busy, done, pass, fail, tmo;
  logic [31:0] rdata [2];
  logic [31:0] idw [2];
  logic [31:0] tsw [2];

  int tests = 0;
  int failures = 0;
  logic [31:0] exp_id [2];
  logic [31:0] exp_ts [2];
  bit          exp_p [2];
  bit          exp_f [2];
  bit          exp_t [2];

  sysid_check u_dut0 (
    .clk(clk), .reset_n(rstn[0]), .start(st[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_readdata(rdata[0]), .avm_waitrequest(wr[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]), .timeout(tmo[0]),
    .id_word(idw[0]), .ts_word(tsw[0])
  );

  sysid_check #(.TIMEOUT(4)) u_dut1 (
    .clk(clk), .reset_n(rstn[1]), .start(st[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_readdata(rdata[1]), .avm_waitrequest(wr[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]), .timeout(tmo[1]),
    .id_word(idw[1]), .ts_word(tsw[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Call when sampled #1 after an edge with the dut freshly in its ID read.
  task automatic run_check(input int sel, input int s0, input int s1, input logic [31:0] d0,
                           input logic [31:0] d1, input bit hold_start, input string name);
    int tlim, cyc, n, a;
    int stall [2];
    bit prev_stall;
    logic prev_addr;
    tlim = (sel == 0) ? 255 : 4;
    exp_p[sel] = 0; exp_f[sel] = 0; exp_t[sel] = 0;
    if (s0 > tlim) begin
      cyc = tlim + 1; exp_f[sel] = 1; exp_t[sel] = 1;
    end else begin
      exp_id[sel] = d0;
      if (s1 > tlim) begin
        cyc = s0 + 1 + tlim + 1; exp_f[sel] = 1; exp_t[sel] = 1;
      end else begin
        exp_ts[sel] = d1;
        cyc = s0 + s1 + 3;
        exp_p[sel] = (d0 == IDX) && (d1 == TSX);
        exp_f[sel] = !exp_p[sel];
      end
    end
    stall[0] = s0; stall[1] = s1; n = 0; prev_stall = 0; prev_addr = 0;
    while (done[sel] !== 1'b1 && n < cyc + 10) begin
      if (prev_stall) begin
        tests++;
        if (rd[sel] !== 1'b1 || addr[sel] !== prev_addr) begin
          failures++;
          $display("FAIL %s hold: rd=%b addr=%b, want rd=1 addr=%b", name, rd[sel], addr[sel], prev_addr);
        end
      end
      tests++;
      if (busy[sel] !== 1'b1) begin
        failures++;
        $display("FAIL %s busy: got %b want 1 at cycle %0d", name, busy[sel], n);
      end
      st[sel] = hold_start;
      prev_stall = 0;
      if (rd[sel] === 1'b1) begin
        a = int'(addr[sel]);
        if (stall[a] > 0) begin
          wr[sel] = 1'b1; rdata[sel] = $urandom; stall[a]--;
          prev_stall = 1; prev_addr = addr[sel];
        end else begin
          wr[sel] = 1'b0; rdata[sel] = (a != 0) ? d1 : d0;
        end
      end else begin
        wr[sel] = 1'b0; rdata[sel] = $urandom;
      end
      @(posedge clk); #1; n++;
    end
    st[sel] = 1'b0; wr[sel] = 1'b0;
    tests++;
    if (n != cyc || done[sel] !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: done=%b after %0d edges, want done=1 after %0d", name, done[sel], n, cyc);
    end
    tests++;
    if (pass[sel] !== exp_p[sel] || fail[sel] !== exp_f[sel] || tmo[sel] !== exp_t[sel]) begin
      failures++;
      $display("FAIL %s verdict: pass=%b fail=%b timeout=%b, want %b %b %b", name,
               pass[sel], fail[sel], tmo[sel], exp_p[sel], exp_f[sel], exp_t[sel]);
    end
    tests++;
    if (idw[sel] !== exp_id[sel] || tsw[sel] !== exp_ts[sel]) begin
      failures++;
      $display("FAIL %s words: id=%h ts=%h, want id=%h ts=%h", name, idw[sel], tsw[sel], exp_id[sel], exp_ts[sel]);
    end
    tests++;
    if (rd[sel] !== 1'b0 || busy[sel] !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: rd=%b busy=%b, want 0 0", name, rd[sel], busy[sel]);
    end
  endtask

  // Idle in DONE to confirm results are sticky, then pulse start.
  task automatic do_start(input int sel, input string name);
    repeat (2) begin
      wr[sel] = 1'($urandom); rdata[sel] = $urandom;
      @(posedge clk); #1;
      tests++;
      if (done[sel] !== 1'b1 || pass[sel] !== exp_p[sel] || fail[sel] !== exp_f[sel] ||
          tmo[sel] !== exp_t[sel] || idw[sel] !== exp_id[sel] || rd[sel] !== 1'b0) begin
        failures++;
        $display("FAIL %s sticky: done=%b pass=%b fail=%b to=%b id=%h rd=%b, want 1 %b %b %b %h 0", name,
                 done[sel], pass[sel], fail[sel], tmo[sel], idw[sel], rd[sel], exp_p[sel], exp_f[sel], exp_t[sel], exp_id[sel]);
      end
    end
    wr[sel] = 1'b0;
    st[sel] = 1'b1;
    @(posedge clk); #1;
    st[sel] = 1'b0;
    tests++;
    if (done[sel] !== 1'b0 || pass[sel] !== 1'b0 || fail[sel] !== 1'b0 || tmo[sel] !== 1'b0 ||
        rd[sel] !== 1'b1 || addr[sel] !== 1'b0 || busy[sel] !== 1'b1 ||
        idw[sel] !== exp_id[sel] || tsw[sel] !== exp_ts[sel]) begin
      failures++;
      $display("FAIL %s restart: done=%b pass=%b fail=%b to=%b rd=%b addr=%b busy=%b id=%h ts=%h", name,
               done[sel], pass[sel], fail[sel], tmo[sel], rd[sel], addr[sel], busy[sel], idw[sel], tsw[sel]);
    end
  endtask

  task automatic test_reset();
    rstn = 2'b00; st = 2'b00; wr = 2'b00; rdata[0] = '0; rdata[1] = '0;
    exp_id[0] = '0; exp_ts[0] = '0; exp_id[1] = '0; exp_ts[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({rd[0], addr[0], busy[0], done[0], pass[0], fail[0], tmo[0]} !== 7'b0 || idw[0] !== '0 || tsw[0] !== '0) begin
      failures++;
      $display("FAIL reset_state: rd=%b addr=%b busy=%b done=%b pass=%b fail=%b to=%b id=%h ts=%h, want all 0",
               rd[0], addr[0], busy[0], done[0], pass[0], fail[0], tmo[0], idw[0], tsw[0]);
    end
    rstn[0] = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rd[0] !== 1'b1 || addr[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL powerup_launch: rd=%b addr=%b busy=%b, want 1 0 1", rd[0], addr[0], busy[0]);
    end
  endtask

  task automatic test_nominal();
    run_check(0, 0, 0, IDX, TSX, 0, "nominal");
    do_start(0, "bad_id_start");
    run_check(0, 0, 0, 32'h0, TSX, 0, "bad_id");
    do_start(0, "stall_start");
    run_check(0, 0, 5, IDX, TSX, 0, "ts_stall5");
  endtask

  task automatic test_start_ignored();
    do_start(0, "ign_start");
    run_check(0, 2, 3, IDX, TSX, 1, "start_held_busy");
  endtask

  task automatic test_timeout();
    rstn[1] = 1'b1;
    @(posedge clk); #1;
    run_check(1, 1000, 0, IDX, TSX, 0, "timeout_id");
    do_start(1, "t4_s1");
    run_check(1, 4, 0, IDX, TSX, 0, "accept_at_limit");
    do_start(1, "t4_s2");
    run_check(1, 0, 5, IDX, TSX, 0, "timeout_ts");
    do_start(1, "t4_s3");
    run_check(1, 0, 4, IDX, TSX, 0, "accept_at_limit_ts");
  endtask

  task automatic test_random();
    int s0, s1;
    logic [31:0] d0, d1;
    for (int i = 0; i < 16; i++) begin
      int sel;
      sel = i % 2;
      s0 = $urandom_range(0, 7);
      s1 = $urandom_range(0, 7);
      case ($urandom_range(0, 2))
        0: d0 = IDX;
        1: d0 = IDX ^ (32'h1 << $urandom_range(0, 31));
        default: d0 = $urandom;
      endcase
      d1 = ($urandom_range(0, 2) != 0) ? TSX : (TSX ^ (32'h1 << $urandom_range(0, 31)));
      do_start(sel, "rand_start");
      run_check(sel, s0, s1, d0, d1, 1'($urandom), "rand");
    end
  endtask

  task automatic test_reset_midread();
    do_start(0, "mid_start");
    wr[0] = 1'b0; rdata[0] = IDX;
    @(posedge clk); #1;
    wr[0] = 1'b1; rdata[0] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rd[0] !== 1'b1 || addr[0] !== 1'b1 || idw[0] !== IDX) begin
      failures++;
      $display("FAIL mid_stall: rd=%b addr=%b id=%h, want 1 1 %h", rd[0], addr[0], idw[0], IDX);
    end
    #2;
    rstn[0] = 1'b0;
    #1;
    exp_id[0] = '0; exp_ts[0] = '0;
    tests++;
    if ({rd[0], addr[0], busy[0], done[0], pass[0], fail[0], tmo[0]} !== 7'b0 || idw[0] !== '0 || tsw[0] !== '0) begin
      failures++;
      $display("FAIL async_reset: rd=%b addr=%b busy=%b done=%b pass=%b fail=%b to=%b id=%h ts=%h, want all 0",
               rd[0], addr[0], busy[0], done[0], pass[0], fail[0], tmo[0], idw[0], tsw[0]);
    end
    @(posedge clk); #1;
    rstn[0] = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (rd[0] !== 1'b1 || addr[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL relaunch: rd=%b addr=%b busy=%b, want 1 0 1", rd[0], addr[0], busy[0]);
    end
    run_check(0, 1, 1, IDX, TSX, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_start_ignored();
    test_timeout();
    test_random();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/sysid_check.md
SYSID_CHECK -- requirements
Module: sysid_check

Interface
REQ-001 Parameter ID_EXPECTED, default 651202559, expected system ID word (word address 0).
REQ-002 Parameter TS_EXPECTED, default 1277427864, expected timestamp word (word address 1).
REQ-003 Parameter TIMEOUT, default 255, max waitrequest cycles per read before abort; legal range 1..65535.
REQ-004 Port clk  input  1  single system clock; all state changes on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  request a re-check; single-cycle pulse or level.
REQ-007 Port avm_address  output  1  word address to sysid slave; 0 = ID, 1 = timestamp.
REQ-008 Port avm_read  output  1  Avalon-MM read strobe.
REQ-009 Port avm_readdata  input  32  read data from sysid slave.
REQ-010 Port avm_waitrequest  input  1  slave stall; read accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-011 Port busy  output  1  high while a check is in progress.
REQ-012 Port done  output  1  high while in DONE; sticky until next check starts.
REQ-013 Port pass  output  1  both words matched, no timeout; valid when done=1.
REQ-014 Port fail  output  1  mismatch or timeout; valid when done=1; pass and fail never both high.
REQ-015 Port timeout  output  1  abort was caused by waitrequest timeout.
REQ-016 Port id_word  output  32  captured ID word.
REQ-017 Port ts_word  output  32  captured timestamp word.

Function
REQ-018 States SHALL be RD_ID, RD_TS, COMPARE, DONE; encoding is free.
REQ-019 RD_ID: avm_read=1, avm_address=0; on accept, capture avm_readdata into id_word, clear wait counter, go RD_TS.
REQ-020 RD_TS: avm_read=1, avm_address=1; on accept, capture avm_readdata into ts_word, clear wait counter, go COMPARE.
REQ-021 COMPARE: avm_read=0; go DONE next edge; pass=1 iff id_word==ID_EXPECTED and ts_word==TS_EXPECTED (full 32-bit compare), else fail=1.
REQ-022 DONE: avm_read=0, done=1, busy=0; hold pass/fail/timeout/id_word/ts_word unchanged.
REQ-023 DONE with start=1: clear done, pass, fail, timeout, wait counter; go RD_ID next edge; id_word/ts_word retain old values until recaptured.
REQ-024 start SHALL be ignored in RD_ID, RD_TS, COMPARE (no restart, no queuing).
REQ-025 avm_address and avm_read SHALL be registered outputs, stable throughout a stalled read (Avalon hold rule).
REQ-026 Wait counter (16-bit, saturating) increments each cycle a read is stalled; when counter==TIMEOUT with waitrequest still high, deassert avm_read, set timeout=1, fail=1, go DONE directly (skip COMPARE).
REQ-027 Accept on the same cycle counter reaches TIMEOUT SHALL count as success (accept wins over timeout).
REQ-028 busy=1 in RD_ID, RD_TS, COMPARE; 0 in DONE.
REQ-029 Zero-wait slave latency: done rises after the 3rd rising edge following entry to RD_ID.

Reset
REQ-030 reset_n low SHALL asynchronously force: state RD_ID, avm_read=0, avm_address=0, busy=0, done=0, pass=0, fail=0, timeout=0, id_word=0, ts_word=0, wait counter=0.
REQ-031 First edge after reset_n release SHALL assert avm_read=1, avm_address=0, busy=1 (automatic check at power-up; no start needed).
REQ-032 reset_n asserted mid-read SHALL drop avm_read immediately without waiting for accept; no partial capture survives.

Verification
REQ-033 Zero-wait slave returning 651202559 / 1277427864 -> addresses 0 then 1 on consecutive cycles, done=1 and pass=1 after 3rd edge, fail=0, timeout=0.
REQ-034 Slave returns ID 0x00000000 -> done=1, fail=1, pass=0, id_word=0, ts_word=1277427864.
REQ-035 waitrequest=1 for 5 cycles on address 1 -> avm_read and avm_address=1 held all 5 stall cycles, then pass=1.
REQ-036 TIMEOUT=4, waitrequest stuck high -> avm_read drops after counter reaches 4, timeout=1, fail=1, done=1, no COMPARE state visited.
REQ-037 start pulsed during RD_TS -> ignored; start pulsed in DONE -> done/pass clear next edge, new read sequence at address 0.
REQ-038 reset_n low during RD_TS stall -> avm_read=0 same cycle, all outputs at reset values; after release, sequence restarts at address 0.
